// File: rtl/fetch_pc_gen.sv
// Fetch-stage next-PC generator: BTB + 2-bit PHT direction prediction, redirect override.
// Optional return address stack compiled in when FETCH_RAS_EN is defined.
module fetch_pc_gen #(
    parameter logic [29:0] RESET_PC    = 30'h18,
    parameter int unsigned PHT_ENTRIES = 64,
    parameter int unsigned RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        rst,
    output logic [29:0] pc_out,
    output logic [28:0] fetch_PC,
    input  logic [29:0] target,
    input  logic [1:0]  btype,
    input  logic        hit,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic        pred_taken,
    output logic [29:0] pred_target,
    input  logic        redirect_valid,
    input  logic [29:0] redirect_target,
    input  logic        upd_valid,
    input  logic [28:0] upd_PC,
    input  logic        upd_taken
);
    localparam int unsigned PhtW = $clog2(PHT_ENTRIES);
    localparam logic [1:0] BtCond = 2'b00;
    localparam logic [1:0] BtCall = 2'b10;
    localparam logic [1:0] BtRet  = 2'b11;

    logic [29:0]     pc_q, pc_d, pc_inc;
    logic [1:0]      pht_q [PHT_ENTRIES];
    logic [PhtW-1:0] rd_idx, wr_idx;
    logic            accept;
    logic            unused_upd;

    assign pc_out      = pc_q;
    assign fetch_PC    = pc_q[29:1];
    assign fetch_valid = ~rst;
    assign pc_inc      = pc_q + 30'd1;
    assign rd_idx      = pc_q[PhtW:1];
    assign wr_idx      = upd_PC[PhtW-1:0];
    assign accept      = fetch_ready & ~redirect_valid;
    assign unused_upd  = ^upd_PC;
    assign pred_taken  = hit & ((btype != BtCond) | pht_q[rd_idx][1]);

`ifdef FETCH_RAS_EN
    localparam int unsigned RasW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(RAS_DEPTH + 1);
    localparam logic [CntW-1:0] RasFull = CntW'(RAS_DEPTH);

    logic [29:0]     ras_q [RAS_DEPTH];
    logic [RasW-1:0] top_q, top_inc;
    logic [CntW-1:0] cnt_q;
    logic            ras_ne, is_ret, push, pop;

    assign ras_ne  = cnt_q != '0;
    assign is_ret  = hit & (btype == BtRet);
    assign push    = accept & hit & (btype == BtCall);
    assign pop     = accept & is_ret & ras_ne;
    assign top_inc = top_q + RasW'(1);

    always_comb begin
        pred_target = pc_inc;
        if (pred_taken) begin
            pred_target = (is_ret & ras_ne) ? ras_q[top_q] : target;
        end
    end

    // Circular stack: a push when full silently overwrites the oldest slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= '0;
            end
        end else if (push) begin
            top_q          <= top_inc;
            ras_q[top_inc] <= pc_inc;
            if (cnt_q != RasFull) begin
                cnt_q <= cnt_q + CntW'(1);
            end
        end else if (pop) begin
            top_q <= top_q - RasW'(1);
            cnt_q <= cnt_q - CntW'(1);
        end
    end
`else
    logic [31:0] unused_ras_depth;

    assign unused_ras_depth = RAS_DEPTH;
    assign pred_target      = pred_taken ? target : pc_inc;
`endif

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_target;
        end else if (fetch_ready) begin
            pc_d = pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Saturating counters; a same-cycle read sees the pre-update value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_taken && pht_q[wr_idx] != 2'b11) begin
                pht_q[wr_idx] <= pht_q[wr_idx] + 2'b01;
            end else if (!upd_taken && pht_q[wr_idx] != 2'b00) begin
                pht_q[wr_idx] <= pht_q[wr_idx] - 2'b01;
            end
        end
    end

endmodule

// File: doc/fetch_pc_gen.md
# fetch_pc_gen

Fetch-stage next-PC generator. Holds the architectural fetch PC, drives the lookup key into `branch_target_buffer`, and combines the BTB's same-cycle `target`/`btype`/`hit` with a 2-bit-counter direction table (and an optional return address stack) to pick the next fetch address. Execute-stage redirects override all predictions. The registered PC drives the instruction-memory request.

## Interface
- `RESET_PC`, 30'h18, word address (PC[31:2]) loaded on reset
- `PHT_ENTRIES`, 64, direction counters; power of two, ≥2
- `RAS_DEPTH`, 8, return stack entries; power of two; used only with `FETCH_RAS_EN`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `pc_out`  out  30  current fetch PC[31:2]
- `fetch_PC`  out  29  BTB lookup key, = `pc_out[29:1]` (PC[31:3])
- `target`  in  30  BTB predicted target, PC[31:2]
- `btype`  in  2  BTB branch type: 00 cond, 01 jump, 10 call, 11 return
- `hit`  in  1  BTB hit
- `fetch_valid`  out  1  `pc_out` is a valid request
- `fetch_ready`  in  1  imem accepts the request this cycle
- `pred_taken`  out  1  current fetch predicted taken
- `pred_target`  out  30  predicted next PC when `pred_taken`, else `pc_out+1`
- `redirect_valid`  in  1  execute mispredict/exception redirect
- `redirect_target`  in  30  redirect PC[31:2]
- `upd_valid`  in  1  resolved conditional-branch update
- `upd_PC`  in  29  PC[31:3] of the resolved branch
- `upd_taken`  in  1  resolved direction

## Operation
- BTB read is combinational from `fetch_PC`; prediction is combinational, and the next PC is registered.
- A BTB hit applies to both words of the 8-byte pair (`pc_out[0]` ignored). Aliased mispredicts are repaired by redirect.
- `pred_taken` = `hit & (btype!=00 | pht[fetch_PC[k-1:0]][1])`, where k = log2(`PHT_ENTRIES`).
- `pred_target` = `target`, except for a return while the RAS is non-empty (`FETCH_RAS_EN` only).
- Next PC, in priority order:
  - `redirect_valid` → `redirect_target` (regardless of `fetch_ready`)
  - else `fetch_ready` → `pred_target`
  - else hold.
- Sequential increment is `pc_out+1`, modulo 2^30 (30'h3FFFFFFF → 0).
- PHT:
  - All counters reset to 2'b01.
  - On `upd_valid`, `pht[upd_PC[k-1:0]]` increments if `upd_taken`, else decrements; saturates at 0 and 3.
  - The update is written at the clock edge. A same-cycle read of the same index sees the old value.
- `fetch_valid` = 0 while `rst` is asserted; 1 in every cycle after reset.

## Timing
- Reset (asynchronous):
  - `pc_out`=`RESET_PC`, `fetch_valid`=0, PHT=01, RAS empty.
  - Combinational outputs follow from these values.
- Mid-operation reset takes effect immediately; any pending redirect or update is discarded.
- Redirect-to-new-PC latency: 1 cycle. A redirect and a BTB hit in the same cycle: redirect wins; PHT is still updated if `upd_valid`.
- Stall (`fetch_ready`=0, no redirect): `pc_out` and the RAS hold; outputs remain stable. PHT updates still occur.
- Throughput: one PC per cycle while `fetch_ready`=1.

## Configuration
- `FETCH_RAS_EN` defined: a circular RAS of `RAS_DEPTH` entries is compiled in. The RAS changes only on an accepted fetch (`fetch_ready`=1, no redirect):
  - Call hit pushes `pc_out+1`. Push when full overwrites the oldest entry; the count saturates at `RAS_DEPTH`.
  - Return hit pops when non-empty; `pred_target`=top.
  - Return hit when empty: no pop; `pred_target`=`target`.
  - Redirects do not repair the RAS.
- `FETCH_RAS_EN` undefined: no RAS storage; a return uses BTB `target` like a jump.

## Test plan
- Reset, `RESET_PC`=30'h18, `fetch_ready`=1, `hit`=0: `pc_out` 18, 19, 1A on successive cycles; `fetch_valid`=1 after release; `pred_taken`=0.
- Stall: `fetch_ready`=0 for 3 cycles at `pc_out`=1A: `pc_out` holds 1A. Raise `fetch_ready`: next cycle 1B.
- Jump: `hit`=1, `btype`=01, `target`=30'h100: `pred_taken`=1 and next `pc_out`=100. With `hit`=1, `btype`=00, counter 01: next `pc_out`=`pc_out+1`.
- PHT training on index 5:
  - Two `upd_taken`=1 updates → cond hit predicts taken.
  - Three more taken then one not-taken → counter 2, still taken.
  - Same-cycle update and read of index 5 uses the old counter.
- Redirect with `fetch_ready`=0 and `hit`=1 jump to 100, `redirect_target`=30'h3FFFFFFF: next `pc_out`=3FFFFFFF. Following sequential PC = 0 (wrap).
- Call at `pc_out`=40 (`btype`=10, `target`=200), then return hit with `target`=999:
  - `FETCH_RAS_EN` defined → `pc_out`=41.
  - Undefined → 999.
  - Return hit with empty RAS → 999.
  - Nine calls with depth 8, then eight returns → the eight most recent return addresses, newest first.
